// File: rtl/alu_pkg.sv
// Shared types and op codes for the iterative multiply/divide unit.
package alu_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        OP_MULT  = MD_MULT,
        OP_MULTU = MD_MULTU,
        OP_DIV   = MD_DIV,
        OP_DIVU  = MD_DIVU,
        OP_MTHI  = MD_MTHI,
        OP_MTLO  = MD_MTLO,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the execute stage and the mul/div unit.
interface alu_muldiv_if #(
    parameter int N = 32
) ();
    import alu_pkg::*;

    logic         in_valid;
    logic         in_ready;
    md_op_t       op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output in_valid, op, A, B,
        input  in_ready, busy, done, div_zero, hi, lo
    );

    modport slave (
        input  in_valid, op, A, B,
        output in_ready, busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/sign_fix.sv
// Conditional two's-complement negate.
module sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] v_i,
    input  logic         neg_i,
    output logic [W-1:0] v_o
);

    assign v_o = neg_i ? (~v_i + W'(1)) : v_i;

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they act unsigned.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_muldiv_if.slave  bus
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    md_state_t      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   m_q, m_d;
    logic           div_q, div_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           dz_q, dz_d;

    logic [N-1:0]   abs_a, abs_b;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem;
    logic [N:0]     psum, prem, pdiff;

`ifdef MULDIV_SIGNED_EN
    logic sgn, sa_q, sb_q;

    assign sgn = (bus.op == OP_MULT) || (bus.op == OP_DIV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q <= 1'b0;
            sb_q <= 1'b0;
        end else if (state_q == IDLE && bus.in_valid) begin
            sa_q <= sgn & bus.A[N-1];
            sb_q <= sgn & bus.B[N-1];
        end
    end

    sign_fix #(.W(N)) u_abs_a (
        .v_i(bus.A), .neg_i(sgn & bus.A[N-1]), .v_o(abs_a)
    );
    sign_fix #(.W(N)) u_abs_b (
        .v_i(bus.B), .neg_i(sgn & bus.B[N-1]), .v_o(abs_b)
    );
    sign_fix #(.W(2*N)) u_fix_p (
        .v_i(acc_q), .neg_i(sa_q ^ sb_q), .v_o(prod)
    );
    sign_fix #(.W(N)) u_fix_q (
        .v_i(acc_q[N-1:0]), .neg_i(sa_q ^ sb_q), .v_o(quo)
    );
    sign_fix #(.W(N)) u_fix_r (
        .v_i(acc_q[2*N-1:N]), .neg_i(sa_q), .v_o(rem)
    );
`else
    assign abs_a = bus.A;
    assign abs_b = bus.B;
    assign prod  = acc_q;
    assign quo   = acc_q[N-1:0];
    assign rem   = acc_q[2*N-1:N];
`endif

    assign psum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign prem  = acc_q[2*N-1:N-1];
    assign pdiff = prem - {1'b0, m_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                dz_d = 1'b0;
                unique case (bus.op)
                    OP_MULT, OP_MULTU: begin
                        state_d = RUN;
                        cnt_d   = '0;
                        acc_d   = {{N{1'b0}}, abs_b};
                        m_d     = abs_a;
                        div_d   = 1'b0;
                    end
                    OP_DIV, OP_DIVU: begin
                        state_d = RUN;
                        cnt_d   = '0;
                        acc_d   = {{N{1'b0}}, abs_a};
                        m_d     = abs_b;
                        div_d   = 1'b1;
                    end
                    OP_MTHI: begin
                        hi_d   = bus.A;
                        done_d = 1'b1;
                    end
                    OP_MTLO: begin
                        lo_d   = bus.A;
                        done_d = 1'b1;
                    end
                    OP_RSV6, OP_RSV7: done_d = 1'b1;
                endcase
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (!div_q)
                    acc_d = {psum, acc_q[N-1:1]};
                else if (prem >= {1'b0, m_q})
                    acc_d = {pdiff[N-1:0], acc_q[N-2:0], 1'b1};
                else
                    acc_d = {acc_q[2*N-2:0], 1'b0};
                if (cnt_q == LAST)
                    state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    // B==0 leaves remainder = |A|, so the sign fix restores A
                    dz_d = (m_q == '0);
                    lo_d = dz_d ? '1 : quo;
                    hi_d = rem;
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised bench for alu_muldiv against a plain-arithmetic HI/LO model.
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int N = 32;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED = 1'b1;
`else
    localparam bit SIGNED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    logic        dz_m = 1'b0;
    int          lat_m;

    alu_muldiv_if #(.N(N)) bus ();

    alu_muldiv #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Architectural effect of one op on HI/LO, straight from the op rules.
    task automatic model(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        longint sa, sb, sp, sq, sr;
        logic [63:0] p;
        logic [31:0] q, r;
        bit sgn;
        sgn = SIGNED && (o == 3'd0 || o == 3'd2);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz_m  = 1'b0;
        lat_m = 0;
        case (o)
            3'd0, 3'd1: begin
                if (sgn) begin
                    sp = sa * sb;
                    p  = 64'(sp);
                end else begin
                    p = {32'b0, a} * {32'b0, b};
                end
                hi_m  = p[63:32];
                lo_m  = p[31:0];
                lat_m = N + 1;
            end
            3'd2, 3'd3: begin
                lat_m = N + 1;
                if (b == 0) begin
                    lo_m = '1;
                    hi_m = a;
                    dz_m = 1'b1;
                end else if (sgn) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo_m = sq[31:0];
                    hi_m = sr[31:0];
                end else begin
                    q = a / b;
                    r = a % b;
                    lo_m = q;
                    hi_m = r;
                end
            end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        logic [31:0] hi0, lo0;
        bit moved;
        cyc = 0;
        moved = 1'b0;
        hi0 = bus.hi;
        lo0 = bus.lo;
        while (!bus.done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!bus.done && (bus.hi !== hi0 || bus.lo !== lo0))
                moved = 1'b1;
        end
        check({tag, ".lat"}, 64'(cyc), 64'(lat_m));
        check({tag, ".stable"}, 64'(moved), 64'(0));
        check({tag, ".hi"}, 64'(bus.hi), 64'(hi_m));
        check({tag, ".lo"}, 64'(bus.lo), 64'(lo_m));
        check({tag, ".dz"}, 64'(bus.div_zero), 64'(dz_m));
        check({tag, ".rdy"}, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic accept(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = md_op_t'(o);
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        model(o, a, b);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        accept(o, a, b);
        wait_done(tag);
    endtask

    initial begin
        logic [2:0] o;
        logic [31:0] a, b;
        int k;
        bus.in_valid = 1'b0;
        bus.op = OP_MULTU;
        bus.A = '0;
        bus.B = '0;
        #1;
        check("rst.rdy", 64'(bus.in_ready), 64'(1));
        check("rst.busy", 64'(bus.busy), 64'(0));
        check("rst.done", 64'(bus.done), 64'(0));
        check("rst.dz", 64'(bus.div_zero), 64'(0));
        check("rst.hilo", {bus.hi, bus.lo}, 64'(0));
        #22;
        rst_n = 1'b1;

        run_op("t1_multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("t2_mult", 3'd0, 32'hFFFFFFFD, 32'h00000005);
        run_op("t3_div", 3'd2, 32'hFFFFFFF9, 32'h00000002);
        run_op("t4_divz", 3'd3, 32'h00000007, 32'h00000000);
        run_op("t4_mtlo", 3'd5, 32'h00001234, 32'h0);
        run_op("minneg", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        run_op("sdivz", 3'd2, 32'h80000005, 32'h0);
        run_op("mthi", 3'd4, 32'hCAFEF00D, 32'h0);
        run_op("nop6", 3'd6, 32'h11111111, 32'h2);
        run_op("nop7", 3'd7, 32'h22222222, 32'h3);

        // Request held while busy must wait for the done cycle.
        accept(3'd1, 32'd3, 32'd4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = OP_DIVU;
        bus.A = 32'd100;
        bus.B = 32'd7;
        #2;
        check("t5.busy_rdy", 64'(bus.in_ready), 64'(0));
        k = 0;
        while (!bus.done && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t5.lat", 64'(k), 64'(N + 1 - 5));
        check("t5.rdy", 64'(bus.in_ready), 64'(1));
        check("t5.hilo", {bus.hi, bus.lo}, {32'h0, 32'h0000000C});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        model(3'd3, 32'd100, 32'd7);
        wait_done("t5_divu");

        // Reset mid-op aborts without a done pulse.
        accept(3'd3, 32'h12345678, 32'h00000013);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        hi_m = '0;
        lo_m = '0;
        dz_m = 1'b0;
        check("t6.busy", 64'(bus.busy), 64'(0));
        check("t6.hilo", {bus.hi, bus.lo}, 64'(0));
        check("t6.done", 64'(bus.done), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done)
                k++;
        end
        check("t6.nodone", 64'(k), 64'(0));
        check("t6.rdy", 64'(bus.in_ready), 64'(1));

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = 32'($urandom_range(1, 20));
                2: begin
                    a = 32'h80000000;
                    b = 32'hFFFFFFFF;
                end
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), o, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
